mu0_ser16_tx: RTL

MU0_SER16_TX -- requirements
Module: mu0_ser16_tx

---
 rtl/mu0_ser16_tx.sv | 107 ++++++++++
 1 files changed

// File: rtl/mu0_ser16_tx.sv
// Serial transmitter for 16-bit words: one start bit (0), sixteen data bits LSB first,
// one stop bit (1), each held CLKS_PER_BIT clocks. Every output comes straight from a flop.
module mu0_ser16_tx #(
  parameter int unsigned CLKS_PER_BIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic [15:0] D,
  output logic        SDout,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLKS_PER_BIT - 1);

  state_t      state, state_nx;
  logic [15:0] shift_reg, shift_nx;
  logic [3:0]  bit_cnt, bit_nx;
  logic [7:0]  div, div_nx;
  logic        sdout_nx, busy_nx, done_nx;
  logic        div_end;

  assign div_end = (div == DIV_MAX);

  // Next values for every register, including the outputs, so that each output
  // is one flop away from its source.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_nx = state;
    shift_nx = shift_reg;
    bit_nx   = bit_cnt;
    div_nx   = div;
    sdout_nx = SDout;
    busy_nx  = Busy;
    done_nx  = 1'b0;

    if (state != IDLE) div_nx = div_end ? 8'd0 : div + 8'd1;

    case (state)
      IDLE: begin
        sdout_nx = 1'b1;
        busy_nx  = 1'b0;
        if (En) begin
          shift_nx = D;
          state_nx = START;
          sdout_nx = 1'b0;
          busy_nx  = 1'b1;
          div_nx   = 8'd0;
          bit_nx   = 4'd0;
        end
      end
      START: begin
        if (div_end) begin
          state_nx = DATA;
          bit_nx   = 4'd0;
          sdout_nx = shift_reg[0];
        end
      end
      DATA: begin
        if (div_end) begin
          if (bit_cnt == 4'd15) begin
            state_nx = STOP;
            sdout_nx = 1'b1;
          end else begin
            bit_nx   = bit_cnt + 4'd1;
            sdout_nx = shift_reg[bit_nx];
          end
        end
      end
      STOP: begin
        // En is deliberately not looked at here; the earliest reload is one idle cycle later.
        if (div_end) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the data word is an ordinary register, so it is cleared by reset like everything else.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      shift_reg <= 16'd0;
      bit_cnt   <= 4'd0;
      div       <= 8'd0;
      SDout     <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      // NOTE: non-blocking so all registers update together from pre-edge values.
      state     <= state_nx;
      shift_reg <= shift_nx;
      bit_cnt   <= bit_nx;
      div       <= div_nx;
      SDout     <= sdout_nx;
      Busy      <= busy_nx;
      Done      <= done_nx;
    end
  end

endmodule
